// File: rtl/spi_flash_ctrl_if.sv
// Memory-bus port bundle for the SPI flash controller.
// The bus master drives the request side; the controller answers.
interface spi_flash_ctrl_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in,
    output write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in,
    input  write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/spi_flash_ctrl.sv
// Read-only SPI flash controller: wakes the flash, then serves
// 32-bit bus reads with mode-0 READ (0x03) transactions.
module spi_flash_ctrl #(
  parameter int CLK_DIV    = 1,
  parameter int WAKE_DELAY = 240
) (
  input  logic             clk,
  input  logic             reset,
  spi_flash_ctrl_if.slave  bus,
  output logic             flash_clk,
  output logic             flash_csn,
  output logic             flash_io0_out,
  output logic             flash_io0_en,
  input  logic             flash_io1_in,
  output logic             flash_io1_en
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(2 * CLK_DIV + 1);
  localparam int WW = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(2 * CLK_DIV - 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAKE_DELAY - 1);

  typedef enum logic [2:0] {
    WAKE_CMD, WAKE_WAIT, IDLE, CMD,
    ADDR, DATA, DONE, GAP
  } state_t;

  state_t          state;
  logic [31:0]     sh;
  logic [31:0]     rx;
  logic [31:0]     rdata;
  logic [4:0]      bitcnt;
  logic [4:0]      last;
  logic [DW-1:0]   divcnt;
  logic [GW-1:0]   gapcnt;
  logic [WW-1:0]   waitcnt;
  logic            ready;
  logic            shifting;
  logic            half_end;
  logic            req_rd;
  logic            req_wr;
  logic            unused_bits;

  always_comb begin
    last = 5'd31;
    unique case (state)
      WAKE_CMD, CMD: last = 5'd7;
      ADDR:          last = 5'd23;
      default:       last = 5'd31;
    endcase
  end

  assign shifting = (state == WAKE_CMD && !flash_csn)
                 || state == CMD
                 || state == ADDR
                 || state == DATA;
  assign half_end = divcnt == DIV_LAST;

  // A request seen during the ready cycle is the one just served.
  assign req_rd = bus.sel_in && bus.read_in && !ready;
  assign req_wr = bus.sel_in && !bus.read_in
               && bus.write_mask_in != 4'd0 && !ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAKE_CMD;
      flash_csn     <= 1'b1;
      flash_clk     <= 1'b0;
      flash_io0_out <= 1'b0;
      ready         <= 1'b0;
      rdata         <= '0;
      rx            <= '0;
      sh            <= {8'hAB, 24'h0};
      bitcnt        <= '0;
      divcnt        <= '0;
      gapcnt        <= '0;
      waitcnt       <= '0;
    end else begin
      ready <= 1'b0;
      rdata <= '0;
      if (shifting) begin
        if (!half_end) begin
          divcnt <= divcnt + DW'(1);
        end else begin
          divcnt <= '0;
          if (!flash_clk) begin
            flash_clk <= 1'b1;
            if (state == DATA)
              rx <= {rx[30:0], flash_io1_in};
          end else begin
            flash_clk     <= 1'b0;
            sh            <= {sh[30:0], 1'b0};
            flash_io0_out <= sh[30];
            bitcnt        <= bitcnt + 5'd1;
            if (bitcnt == last) begin
              bitcnt <= '0;
              unique case (state)
                WAKE_CMD: begin
                  state     <= WAKE_WAIT;
                  flash_csn <= 1'b1;
                end
                CMD:     state <= ADDR;
                ADDR:    state <= DATA;
                default: state <= DONE;
              endcase
            end
          end
        end
      end
      unique case (state)
        WAKE_CMD: begin
          if (flash_csn) begin
            flash_csn     <= 1'b0;
            flash_io0_out <= sh[31];
          end
        end
        WAKE_WAIT: begin
          waitcnt <= waitcnt + WW'(1);
          if (waitcnt == WAIT_LAST)
            state <= IDLE;
        end
        IDLE: begin
          if (req_rd) begin
            state         <= CMD;
            flash_csn     <= 1'b0;
            sh            <= {8'h03, bus.address_in[23:2], 2'b00};
            flash_io0_out <= 1'b0;
            divcnt        <= '0;
            bitcnt        <= '0;
          end else if (req_wr) begin
            ready <= 1'b1;
          end
        end
        DONE: begin
          flash_csn <= 1'b1;
          ready     <= 1'b1;
          rdata     <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
          state     <= GAP;
          gapcnt    <= GAP_LOAD;
        end
        GAP: begin
          if (gapcnt == '0)
            state <= IDLE;
          else
            gapcnt <= gapcnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_out      = ready;
  assign bus.read_value_out = bus.sel_in ? rdata : 32'd0;
  assign flash_io0_en       = 1'b1;
  assign flash_io1_en       = 1'b0;

  // Upper address byte wraps, writes carry no data into flash.
  assign unused_bits = ^{bus.address_in[31:24],
                         bus.address_in[1:0],
                         bus.write_value_in};
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Bench for spi_flash_ctrl: flash model, vector table and
// hand sequences for wake, writes, CLK_DIV=3 and reset abort.
module tb_spi_flash_ctrl;
  localparam int WD = 240;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_flash_ctrl_if b1();
  spi_flash_ctrl_if b3();

  logic fclk1, csn1, io0_1, en0_1, en1_1;
  logic fclk3, csn3, io0_3, en0_3, en1_3;
  logic io1 = 1'b0;

  spi_flash_ctrl #(.CLK_DIV(1), .WAKE_DELAY(WD)) u1 (
    .clk(clk), .reset(reset), .bus(b1),
    .flash_clk(fclk1), .flash_csn(csn1),
    .flash_io0_out(io0_1), .flash_io0_en(en0_1),
    .flash_io1_in(io1), .flash_io1_en(en1_1)
  );

  spi_flash_ctrl #(.CLK_DIV(3), .WAKE_DELAY(WD)) u3 (
    .clk(clk), .reset(reset), .bus(b3),
    .flash_clk(fclk3), .flash_csn(csn3),
    .flash_io0_out(io0_3), .flash_io0_en(en0_3),
    .flash_io1_in(io1), .flash_io1_en(en1_3)
  );

  bit  msel = 1'b0;
  wire m_clk = msel ? fclk3 : fclk1;
  wire m_csn = msel ? csn3 : csn1;
  wire m_io0 = msel ? io0_3 : io0_1;

  // Flash model: 0x100..0x103 hold 13 05 00 00, else addr+0x11.
  function automatic logic [7:0] fmem(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h13;
      24'h000101: return 8'h05;
      24'h000102: return 8'h00;
      24'h000103: return 8'h00;
      default:    return a[7:0] + 8'h11;
    endcase
  endfunction

  int          rcnt = 0;
  int          last_rcnt = 0;
  logic [31:0] fsh = '0;
  logic [31:0] fcmd = '0;
  logic [7:0]  last_byte = '0;

  always @(negedge m_csn) begin
    rcnt = 0;
    fsh  = '0;
  end

  always @(posedge m_csn) begin
    last_rcnt = rcnt;
    last_byte = fsh[7:0];
  end

  always @(posedge m_clk) begin
    if (m_csn === 1'b0) begin
      fsh = {fsh[30:0], m_io0};
      rcnt++;
      if (rcnt == 32) fcmd = fsh;
    end
  end

  always @(negedge m_clk) begin : fl_out
    int k;
    logic [7:0] b;
    if (m_csn === 1'b0 && rcnt >= 32 && rcnt < 64) begin
      k   = rcnt - 32;
      b   = fmem(fcmd[23:0] + 24'(k / 8));
      io1 = b[3'(7 - k % 8)];
    end
  end

  // Monitors sampled 2 ns after each rising edge.
  int   cyc = 0;
  int   run1 = 0;
  int   last_run1 = 0;
  int   io0_bad = 0;
  int   rv_bad = 0;
  int   rdy1_cnt = 0;
  int   rdy3_cnt = 0;
  logic p_io0_1 = 1'b0;
  logic p_io0_3 = 1'b0;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #2;
    if (fclk1 === 1'b1 && io0_1 !== p_io0_1) io0_bad++;
    if (fclk3 === 1'b1 && io0_3 !== p_io0_3) io0_bad++;
    p_io0_1 = io0_1;
    p_io0_3 = io0_3;
    if (csn1 === 1'b1) begin
      run1++;
    end else begin
      if (run1 > 0) last_run1 = run1;
      run1 = 0;
    end
    if (b1.sel_in === 1'b0 && b1.read_value_out !== 32'd0) rv_bad++;
    if (b3.sel_in === 1'b0 && b3.read_value_out !== 32'd0) rv_bad++;
    if (b1.ready_out === 1'b1) rdy1_cnt++;
    if (b3.ready_out === 1'b1) rdy3_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic drive(input bit u, input logic s, input logic r,
                       input logic [3:0] m, input logic [31:0] a);
    if (u) begin
      b3.sel_in = s; b3.read_in = r;
      b3.write_mask_in = m; b3.address_in = a;
    end else begin
      b1.sel_in = s; b1.read_in = r;
      b1.write_mask_in = m; b1.address_in = a;
    end
  endtask

  task automatic wait_mcsn(input logic lvl, input int lim,
                           output int n);
    n = 0;
    while (m_csn !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (m_csn !== lvl) n = -1;
  endtask

  task automatic wait_rdy(input bit u, input int lim, output int n);
    logic r;
    n = 0;
    r = u ? b3.ready_out : b1.ready_out;
    while (r !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
      r = u ? b3.ready_out : b1.ready_out;
    end
    if (r !== 1'b1) n = -1;
  endtask

  // Issue a read and check csn gap, latency, data and flash command.
  task automatic do_read(input string nm, input bit u,
                         input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] exp_d,
                         input logic [23:0] exp_fa,
                         input int exp_lat, input int exp_gap,
                         input bit keep);
    int n, t0;
    logic [31:0] rv;
    drive(u, 1'b1, 1'b1, m, a);
    wait_mcsn(1'b0, 2000, n);
    if (n < 0) begin
      fail_to({nm, "_csn"});
      drive(u, 1'b0, 1'b0, 4'h0, 32'h0);
      return;
    end
    t0 = cyc;
    if (exp_gap > 0) chk({nm, "_gap"}, 32'(last_run1), 32'(exp_gap));
    wait_rdy(u, 2000, n);
    if (n < 0) begin
      fail_to({nm, "_rdy"});
      drive(u, 1'b0, 1'b0, 4'h0, 32'h0);
      return;
    end
    rv = u ? b3.read_value_out : b1.read_value_out;
    chk({nm, "_lat"}, 32'(cyc - t0 + 1), 32'(exp_lat));
    chk({nm, "_data"}, rv, exp_d);
    chk({nm, "_cmd"}, fcmd, {8'h03, exp_fa});
    if (u) chk({nm, "_idle_rv"}, b1.read_value_out, 32'd0);
    if (!keep) drive(u, 1'b0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(u ? b3.ready_out : b1.ready_out), 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [23:0] faddr;
    int          gap;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n, rc;
    vt[0] = '{32'h0000_0100, 4'h0, 32'h0000_0513, 24'h000100, WD + 1};
    vt[1] = '{32'h0000_0103, 4'h0, 32'h0000_0513, 24'h000100, 2};
    vt[2] = '{32'h0000_0000, 4'h0, 32'h1413_1211, 24'h000000, 2};
    vt[3] = '{32'h0000_0004, 4'h0, 32'h1817_1615, 24'h000004, 2};
    vt[4] = '{32'h0100_0100, 4'h0, 32'h0000_0513, 24'h000100, 2};
    vt[5] = '{32'h00FF_FFFC, 4'h0, 32'h100F_0E0D, 24'hFFFFFC, 2};
    vt[6] = '{32'h0000_0008, 4'hF, 32'h1C1B_1A19, 24'h000008, 2};

    b1.write_value_in = 32'hDEAD_BEEF;
    b3.write_value_in = 32'h0;
    drive(1'b0, 1'b1, 1'b1, 4'h0, vt[0].addr);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("rst_csn", 32'(csn1), 32'd1);
    chk("rst_fclk", 32'(fclk1), 32'd0);
    chk("rst_io0", 32'(io0_1), 32'd0);
    chk("rst_ready", 32'(b1.ready_out), 32'd0);
    chk("rst_rv", b1.read_value_out, 32'd0);
    reset = 1'b0;

    wait_mcsn(1'b0, 20, n);
    if (n < 0) fail_to("wake_start");
    wait_mcsn(1'b1, 100, n);
    if (n < 0) fail_to("wake_end");
    chk("wake_bits", 32'(last_rcnt), 32'd8);
    chk("wake_cmd", 32'(last_byte), 32'hAB);

    for (int i = 0; i < 7; i++)
      do_read($sformatf("rd%0d", i), 1'b0, vt[i].addr, vt[i].mask,
              vt[i].data, vt[i].faddr, 130, vt[i].gap, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);

    repeat (4) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h40);
    @(negedge clk);
    chk("wr_ready", 32'(b1.ready_out), 32'd1);
    chk("wr_rv", b1.read_value_out, 32'd0);
    chk("wr_csn", 32'(csn1), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    chk("wr_pulse", 32'(b1.ready_out), 32'd0);

    rc = rdy1_cnt;
    drive(1'b0, 1'b1, 1'b0, 4'h0, 32'h40);
    repeat (4) @(negedge clk);
    chk("wr_nomask", 32'(rdy1_cnt - rc), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);

    msel = 1'b1;
    do_read("div3", 1'b1, 32'h0000_0103, 4'h0, 32'h0000_0513,
            24'h000100, 386, 0, 1'b0);
    repeat (4) @(negedge clk);
    msel = 1'b0;

    drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0);
    wait_mcsn(1'b0, 100, n);
    if (n < 0) fail_to("abort_start");
    repeat (20) @(negedge clk);
    rc = rdy1_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_csn", 32'(csn1), 32'd1);
    chk("abort_fclk", 32'(fclk1), 32'd0);
    chk("abort_ready", 32'(b1.ready_out), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_mcsn(1'b0, 20, n);
    if (n < 0) fail_to("rewake_start");
    wait_mcsn(1'b1, 100, n);
    if (n < 0) fail_to("rewake_end");
    chk("rewake_bits", 32'(last_rcnt), 32'd8);
    chk("rewake_cmd", 32'(last_byte), 32'hAB);
    repeat (4) @(negedge clk);
    chk("abort_no_ready", 32'(rdy1_cnt - rc), 32'd0);

    chk("io0_stable", 32'(io0_bad), 32'd0);
    chk("rv_zero_unsel", 32'(rv_bad), 32'd0);
    chk("ready_count1", 32'(rdy1_cnt), 32'd8);
    chk("ready_count3", 32'(rdy3_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
